mc_control_unit: RTL and testbench

Multi-cycle control FSM for the MIPS datapath: the block that drives the program counter's `PCWre`/`PCSrc` inputs and every other datapath enable. It sequences each instruction through IF/ID/EXE/MEM/WB states. It uses the registered IR opcode/funct and the ALU `zero` flag to pick the next state and the next-PC source.

---
 rtl/mc_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and decodes every datapath enable.
// Latency: j/jal/jr 2 cycles, beq/bne 3, R/addi/ori/sw 4, lw 5; halt parks in HALT until Reset.
// No backpressure; MCCU_ILLEGAL_TRAP_EN turns undefined encodings into a sticky HALT trap.
module mc_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] DST_RA  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_RD  = 2'b10;

  state_t cur_state;
  state_t nxt_state;

  // Instruction decode from the held IR fields
  logic is_r, is_j, is_jal, is_jr, is_beq, is_bne;
  logic is_addi, is_ori, is_lw, is_sw, is_halt;
  logic r_alu_fn, op_known, undef_enc, br_taken;
  logic [2:0] r_alu_op;

  always_comb begin
    is_r     = (opcode == OP_R);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_addi  = (opcode == OP_ADDI);
    is_ori   = (opcode == OP_ORI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_halt  = (opcode == OP_HALT);
    is_jr    = is_r && (funct == FN_JR);

    r_alu_fn = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: r_alu_fn = 1'b0;
    endcase

    op_known  = is_r || is_j || is_jal || is_beq || is_bne || is_addi ||
                is_ori || is_lw || is_sw || is_halt;
    undef_enc = !op_known || (is_r && !r_alu_fn && !is_jr);
    br_taken  = (is_beq && zero) || (is_bne && !zero);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Raw enables; the write strobes are gated with Reset below
  logic       pc_wre, ir_wre, reg_wre, m_rd, m_wr;
  logic [1:0] pc_src, reg_dst;
  logic       wr_reg_d_src, db_data_src, alu_src_b, ext_sel;
  logic [2:0] alu_op;

  always_comb begin
    nxt_state    = S_IF;
    pc_wre       = 1'b0;
    pc_src       = PC_SEQ;
    ir_wre       = 1'b0;
    reg_wre      = 1'b0;
    reg_dst      = DST_RA;
    wr_reg_d_src = 1'b0;
    db_data_src  = 1'b0;
    alu_src_b    = 1'b0;
    ext_sel      = 1'b0;
    alu_op       = ALU_ADD;
    m_rd         = 1'b0;
    m_wr         = 1'b0;

    case (cur_state)
      S_IF: begin
        ir_wre    = 1'b1;
        nxt_state = S_ID;
      end

      S_ID: begin
        if (is_halt) begin
          nxt_state = S_HALT;
        end else if (undef_enc) begin
`ifdef MCCU_ILLEGAL_TRAP_EN
          nxt_state = S_HALT;
`else
          pc_wre    = 1'b1;
          nxt_state = S_IF;
`endif
        end else if (is_j) begin
          pc_wre    = 1'b1;
          pc_src    = PC_JMP;
          nxt_state = S_IF;
        end else if (is_jal) begin
          pc_wre       = 1'b1;
          pc_src       = PC_JMP;
          reg_wre      = 1'b1;
          reg_dst      = DST_RA;
          wr_reg_d_src = 1'b0;
          nxt_state    = S_IF;
        end else if (is_jr) begin
          pc_wre    = 1'b1;
          pc_src    = PC_RS;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_EXE;
        end
      end

      S_EXE: begin
        if (is_addi || is_lw || is_sw) begin
          alu_src_b = 1'b1;
          ext_sel   = 1'b1;
          alu_op    = ALU_ADD;
        end else if (is_ori) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_OR;
        end else if (is_beq || is_bne) begin
          alu_op    = ALU_SUB;
        end else if (is_r) begin
          alu_op    = r_alu_op;
        end

        // Branches resolve here so the PC sees PCSrc before the mid-cycle negedge
        if (is_beq || is_bne) begin
          pc_wre    = 1'b1;
          pc_src    = br_taken ? PC_BR : PC_SEQ;
          nxt_state = S_IF;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end

      S_MEM: begin
        if (is_sw) begin
          m_wr      = 1'b1;
          pc_wre    = 1'b1;
          nxt_state = S_IF;
        end else if (is_lw) begin
          m_rd      = 1'b1;
          nxt_state = S_WB;
        end else begin
          nxt_state = S_IF;
        end
      end

      S_WB: begin
        reg_wre      = 1'b1;
        pc_wre       = 1'b1;
        reg_dst      = is_r ? DST_RD : DST_RT;
        wr_reg_d_src = 1'b1;
        db_data_src  = is_lw;
        nxt_state    = S_IF;
      end

      S_HALT: begin
        nxt_state = S_HALT;
      end

      default: begin
        nxt_state = S_IF;
      end
    endcase
  end

`ifdef MCCU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      illegal_q <= 1'b0;
    end else if (cur_state == S_ID && undef_enc && !is_halt) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state     = cur_state;
  assign PCWre     = pc_wre  & Reset;
  assign IRWre     = ir_wre  & Reset;
  assign RegWre    = reg_wre & Reset;
  assign mRD       = m_rd    & Reset;
  assign mWR       = m_wr    & Reset;
  assign PCSrc     = pc_src;
  assign RegDst    = reg_dst;
  assign WrRegDSrc = wr_reg_d_src;
  assign DBDataSrc = db_data_src;
  assign ALUSrcB   = alu_src_b;
  assign ExtSel    = ext_sel;
  assign ALUOp     = alu_op;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level model compared every negedge, plus literal probes.
module tb_mc_control_unit;

  logic       CLK;
  logic       Reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] state;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       DBDataSrc;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [2:0] ALUOp;
  logic       mRD;
  logic       mWR;
  logic       illegal;

  mc_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
    .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .illegal(illegal)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

`ifdef MCCU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int C_R = 0, C_JR = 1, C_J = 2, C_JAL = 3, C_BR = 4, C_ADDI = 5;
  localparam int C_ORI = 6, C_LW = 7, C_SW = 8, C_HALT = 9, C_UNDEF = 10;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return C_JR;
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010) return C_R;
        return C_UNDEF;
      end
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b000100, 6'b000101: return C_BR;
      6'b001000: return C_ADDI;
      6'b001101: return C_ORI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b111111: return C_HALT;
      default:   return C_UNDEF;
    endcase
  endfunction

  // State walk of one instruction; element 0 is the first state
  function automatic logic [4:0][2:0] seq_of(input int c);
    logic [4:0][2:0] s;
    s = '0;
    case (c)
      C_R, C_ADDI, C_ORI: begin s[1] = 3'd1; s[2] = 3'd2; s[3] = 3'd4; end
      C_LW:               begin s[1] = 3'd1; s[2] = 3'd2; s[3] = 3'd3; s[4] = 3'd4; end
      C_SW:               begin s[1] = 3'd1; s[2] = 3'd2; s[3] = 3'd3; end
      C_BR:               begin s[1] = 3'd1; s[2] = 3'd2; end
      C_HALT:             begin s[1] = 3'd1; s[2] = 3'd7; end
      C_UNDEF:            begin s[1] = 3'd1; if (TRAP) s[2] = 3'd7; end
      default:            s[1] = 3'd1;
    endcase
    return s;
  endfunction

  function automatic int len_of(input int c);
    case (c)
      C_R, C_ADDI, C_ORI, C_SW: return 4;
      C_LW:                     return 5;
      C_BR, C_HALT:             return 3;
      C_UNDEF:                  return TRAP ? 3 : 2;
      default:                  return 2;
    endcase
  endfunction

  function automatic logic [19:0] mk(input int st, pcw, psrc, irw, rw, rdst, wsrc,
                                     dbs, bsrc, ext, aop, mrd, mwr, ill);
    logic [2:0] s3, a3;
    logic [1:0] p2, d2;
    s3 = st[2:0]; a3 = aop[2:0]; p2 = psrc[1:0]; d2 = rdst[1:0];
    return {s3, pcw[0], p2, irw[0], rw[0], d2, wsrc[0], dbs[0], bsrc[0], ext[0],
            a3, mrd[0], mwr[0], ill[0]};
  endfunction

  function automatic int r_aluop(input logic [5:0] fn);
    case (fn)
      6'b100010: return 1;
      6'b100100: return 2;
      6'b100101: return 3;
      6'b101010: return 4;
      default:   return 0;
    endcase
  endfunction

  // Expected outputs for an instruction class sitting in a given phase
  function automatic logic [19:0] exp_vec(input int st, input int c, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z,
                                          input logic rst_n, input logic ill);
    int pcw, psrc, irw, rw, rdst, wsrc, dbs, bsrc, ext, aop, mrd, mwr;
    pcw = 0; psrc = 0; irw = 0; rw = 0; rdst = 0; wsrc = 0;
    dbs = 0; bsrc = 0; ext = 0; aop = 0; mrd = 0; mwr = 0;
    if (st == 0) irw = 1;
    if (st == 1) begin
      if (c == C_J)  begin pcw = 1; psrc = 3; end
      if (c == C_JAL) begin pcw = 1; psrc = 3; rw = 1; end
      if (c == C_JR) begin pcw = 1; psrc = 2; end
      if (c == C_UNDEF && !TRAP) pcw = 1;
    end
    if (st == 2) begin
      if (c == C_ADDI || c == C_LW || c == C_SW) begin bsrc = 1; ext = 1; end
      if (c == C_ORI) begin bsrc = 1; aop = 3; end
      if (c == C_R) aop = r_aluop(fn);
      if (c == C_BR) begin
        aop = 1; pcw = 1;
        psrc = ((op == 6'b000100) ? z : !z) ? 1 : 0;
      end
    end
    if (st == 3) begin
      if (c == C_LW) mrd = 1;
      if (c == C_SW) begin mwr = 1; pcw = 1; end
    end
    if (st == 4) begin
      rw = 1; pcw = 1; wsrc = 1;
      rdst = (c == C_R) ? 2 : 1;
      dbs  = (c == C_LW) ? 1 : 0;
    end
    if (!rst_n) begin pcw = 0; irw = 0; rw = 0; mrd = 0; mwr = 0; end
    return mk(st, pcw, psrc, irw, rw, rdst, wsrc, dbs, bsrc, ext, aop, mrd, mwr, ill ? 1 : 0);
  endfunction

  // Model: position within the current instruction's state walk
  int m_idx = 0;
  bit m_ill = 1'b0;

  always @(posedge CLK or negedge Reset) begin
    int c;
    logic [4:0][2:0] s;
    if (!Reset) begin
      m_idx = 0;
      m_ill = 1'b0;
    end else begin
      c = cls_of(opcode, funct);
      s = seq_of(c);
      if (s[m_idx] != 3'd7) begin
        if (m_idx == 1 && c == C_UNDEF && TRAP) m_ill = 1'b1;
        m_idx = (m_idx + 1 == len_of(c)) ? 0 : m_idx + 1;
      end
    end
  end

  logic [19:0] dut_vec;
  assign dut_vec = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
                    ALUSrcB, ExtSel, ALUOp, mRD, mWR, illegal};

  always @(negedge CLK) begin
    int c;
    logic [4:0][2:0] s;
    if (chk_en) begin
      c = cls_of(opcode, funct);
      s = seq_of(c);
      check($sformatf("cycle op=%b fn=%b st%0d", opcode, funct, s[m_idx]), {12'd0, dut_vec},
            {12'd0, exp_vec(int'(s[m_idx]), c, opcode, funct, zero, Reset, m_ill)});
    end
  end

  // Entered just after the posedge into IF; probe_at picks which phase gets a literal check
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int n, input int probe_at, input logic [19:0] probe);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == probe_at) check($sformatf("probe op=%b fn=%b ph%0d", op, fn, i),
                               {12'd0, dut_vec}, {12'd0, probe});
      @(posedge CLK);
    end
    #2;
    check($sformatf("cpi op=%b fn=%b", op, fn), {29'd0, state}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK); #2 Reset = 1'b0;
    #1 check("async_reset", {12'd0, dut_vec}, 32'd0);
    @(posedge CLK); #2 Reset = 1'b1;
  endtask

  initial begin
    logic [2:0] first_seq [4];
    first_seq = '{3'd0, 3'd1, 3'd2, 3'd4};
    Reset = 1'b0; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_vec", {12'd0, dut_vec}, 32'd0);
    chk_en = 1'b1;
    @(posedge CLK); #2 Reset = 1'b1;

    // First add: literal walk 0,1,2,4 then back to 0
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("first_state%0d", i), {29'd0, state}, {29'd0, first_seq[i]});
      check($sformatf("first_wb%0d", i), {29'd0, RegWre, PCWre, IRWre},
            (i == 3) ? 32'b110 : ((i == 0) ? 32'b001 : 32'b000));
    end
    @(posedge CLK); #2;
    check("first_cpi", {29'd0, state}, 32'd0);

    run_instr(6'b000100, 6'd0, 1'b1, 3, 2, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_instr(6'b000100, 6'd0, 1'b0, 3, 2, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_instr(6'b000101, 6'd0, 1'b0, 3, 2, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_instr(6'b000101, 6'd0, 1'b1, 3, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b100011, 6'd0, 1'b0, 5, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    run_instr(6'b100011, 6'd0, 1'b0, 5, 3, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run_instr(6'b100011, 6'd0, 1'b0, 5, 4, mk(4, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    run_instr(6'b101011, 6'd0, 1'b0, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    run_instr(6'b101011, 6'd0, 1'b0, 4, 3, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    run_instr(6'b000011, 6'd0, 1'b0, 2, 1, mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b000000, 6'b001000, 1'b0, 2, 1, mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b000010, 6'd0, 1'b0, 2, 1, mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b001101, 6'd0, 1'b0, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0));
    run_instr(6'b001000, 6'd0, 1'b0, 4, 3, mk(4, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b000000, 6'b100010, 1'b0, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_instr(6'b000000, 6'b100100, 1'b0, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    run_instr(6'b000000, 6'b100101, 1'b1, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    run_instr(6'b000000, 6'b101010, 1'b0, 4, 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0));
    run_instr(6'b000000, 6'b100101, 1'b0, 4, 3, mk(4, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
`ifndef MCCU_ILLEGAL_TRAP_EN
    run_instr(6'b010101, 6'd0, 1'b0, 2, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(6'b000000, 6'b000001, 1'b0, 2, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    opcode = 6'b010101; funct = 6'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("trap_state", {29'd0, state}, 32'd7);
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("trap_sticky", {12'd0, dut_vec}, {12'd0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    pulse_reset();
    check("trap_cleared", {31'd0, illegal}, 32'd0);
    run_instr(6'b000000, 6'b100000, 1'b0, 4, -1, 20'd0);
`endif

    // Halt: held for 20 cycles, then only Reset leaves it
    opcode = 6'b111111; funct = 6'd0;
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("halt_hold%0d", i), {12'd0, dut_vec},
            {12'd0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    end
    pulse_reset();

    // Reset mid-EXE of an add: no WB writes afterwards
    opcode = 6'b000000; funct = 6'b100000;
    repeat (2) @(posedge CLK);
    pulse_reset();
    run_instr(6'b000000, 6'b100000, 1'b0, 4, 3, mk(4, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
